// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU and its two-requester arbiter front end.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;
  localparam int unsigned ALU_OPW   = 4;
  localparam int unsigned CNTW      = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1011;
  localparam logic [3:0] OP_SRA = 4'b1101;

  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_S = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus zero/sign/carry/overflow flags; unknown opcodes give zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result_c,
  output logic             zf_c,
  output logic             sf_c,
  output logic             cf_c,
  output logic             vf_c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] res;
  logic             cf;
  logic             vf;

  // Carry on SUB is the borrow; carry on SHL is the last bit shifted out.
  always_comb begin
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    case (op)
      OP_ADD: begin
        {cf, res} = {1'b0, a} + {1'b0, b};
        vf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {cf, res} = {1'b0, a} - {1'b0, b};
        vf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_SLT: res = WIDTH'($signed(a) < $signed(b));
      OP_SHL: {cf, res} = {1'b0, a} << b[SHW-1:0];
      OP_SRA: res = WIDTH'($signed(a) >>> b[SHW-1:0]);
      default: res = '0;
    endcase
  end

  assign result_c = res;
  assign zf_c     = (res == '0);
  assign sf_c     = res[WIDTH-1];
  assign cf_c     = cf;
  assign vf_c     = vf;

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time goes first.
module rr_arb2 (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic last_grant,
  output logic grant0_c,
  output logic grant1_c
);

  assign grant0_c = req0_valid & (~req1_valid | last_grant);
  assign grant1_c = req1_valid & (~req0_valid | ~last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, one op in flight, id-tagged responses.
// Optional per-requester completion counters enabled by ALU_ARB_CNT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;

  logic             grant0_c, grant1_c;
  logic [WIDTH-1:0] alu_result_c;
  logic             alu_z_c, alu_s_c, alu_c_c, alu_v_c;

  rr_arb2 u_rr_arb2 (
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .last_grant (last_grant_q),
    .grant0_c   (grant0_c),
    .grant1_c   (grant1_c)
  );

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result_c (alu_result_c),
    .zf_c     (alu_z_c),
    .sf_c     (alu_s_c),
    .cf_c     (alu_c_c),
    .vf_c     (alu_v_c)
  );

  assign req0_ready = (state_q == IDLE) & grant0_c;
  assign req1_ready = (state_q == IDLE) & grant1_c;

  // Next-state and datapath capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          a_d          = grant1_c ? req1_a  : req0_a;
          b_d          = grant1_c ? req1_b  : req0_b;
          op_d         = grant1_c ? req1_op : req0_op;
          id_d         = grant1_c;
          last_grant_d = grant1_c;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d        = alu_result_c;
        rsp_flags_d[FLG_Z]  = alu_z_c;
        rsp_flags_d[FLG_S]  = alu_s_c;
        rsp_flags_d[FLG_C]  = alu_c_c;
        rsp_flags_d[FLG_V]  = alu_v_c;
        rsp_id_d            = id_q;
        rsp_valid_d         = 1'b1;
        state_d             = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_CNT_EN
  logic [CNTW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Count completed responses per requester; wraps naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rsp_valid_q && rsp_ready) begin
      if (rsp_id_q) cnt1_d = cnt1_q + CNTW'(1);
      else          cnt0_d = cnt0_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
